// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_PERF_EN (performance counters in instr_fetch_unit).
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } fetch_slot_t;

  // Build an empty (bubble) slot carrying the given NOP encoding.
  function automatic fetch_slot_t empty_slot(input logic [31:0] nop);
    fetch_slot_t s;
    s.instr = nop;
    s.pc4   = 32'h0;
    s.valid = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Output slot plus one-entry hold buffer for the fetch stage.
// A load goes straight into the slot when the slot is free (empty or being
// consumed), otherwise into the hold entry. A consume with a waiting hold
// entry promotes it into the slot. Flush empties both and wins over all else.
// Optional feature macro: FETCH_PERF_EN (exposes a slot-load strobe).
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load_i,
  input  logic [31:0] load_instr_i,
  input  logic [31:0] load_pc4_i,
  input  logic        consume_i,
  input  logic        flush_i,
  output fetch_slot_t slot_o,
  output logic        busy_o
`ifdef FETCH_PERF_EN
  ,
  output logic        full_o,
  output logic        slot_load_o
`endif
);

  fetch_slot_t slot_q, slot_d;
  fetch_slot_t hold_q, hold_d;
  fetch_slot_t incoming;
  logic        slot_load;

  assign incoming = '{instr: load_instr_i, pc4: load_pc4_i, valid: 1'b1};

  // Next contents of slot and hold entry.
  always_comb begin
    slot_d    = slot_q;
    hold_d    = hold_q;
    slot_load = 1'b0;
    if (flush_i) begin
      slot_d = empty_slot(NOP_INSTR);
      hold_d = empty_slot(NOP_INSTR);
    end else if (consume_i && hold_q.valid) begin
      slot_d    = hold_q;
      hold_d    = empty_slot(NOP_INSTR);
      slot_load = 1'b1;
    end else if (load_i && (!slot_q.valid || consume_i)) begin
      slot_d    = incoming;
      slot_load = 1'b1;
    end else if (load_i) begin
      hold_d = incoming;
    end else if (consume_i) begin
      slot_d = empty_slot(NOP_INSTR);
    end
  end

  // Slot and hold registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      slot_q <= empty_slot(NOP_INSTR);
      hold_q <= empty_slot(NOP_INSTR);
    end else begin
      slot_q <= slot_d;
      hold_q <= hold_d;
    end
  end

  assign slot_o = slot_q;
  assign busy_o = slot_q.valid;
`ifdef FETCH_PERF_EN
  assign full_o      = hold_q.valid;
  assign slot_load_o = slot_load;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch FSM, and the skid buffer that
// feeds the fetch/decode register. Redirects flush and restart at the target;
// a request that is still outstanding at redirect time is drained and dropped.
// Handshake: imem_req stays high with imem_addr stable until imem_ack; an ack
// may come in the same cycle as the request. The slot is consumed in any
// cycle with valid_out=1 and stall=0.
// Optional feature macro: FETCH_PERF_EN (perf_fetched/perf_stall_cyc/perf_flushed).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr_out,
  output logic [31:0]  pc_out,
  output logic         valid_out,
  output fetch_state_t dbg_state_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall_cyc,
  output logic [31:0]  perf_flushed
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  fetch_slot_t  slot;
  logic         slot_busy;
  logic         consume;
  logic         slot_free;
  logic         req_state;
  logic         accept;
  logic [31:0]  pc_plus4;

  assign consume   = slot_busy && !stall;
  assign slot_free = !slot_busy || !stall;
  assign req_state = (state_q == REQ) || (state_q == WAIT);
  assign accept    = req_state && imem_ack && !redirect;
  assign pc_plus4  = pc_q + PC_STEP;

`ifdef FETCH_PERF_EN
  logic hold_full;
  logic slot_load;
`endif

  fetch_skid_buf #(.NOP_INSTR(NOP_INSTR)) u_skid (
    .Clk          (Clk),
    .Rst          (Rst),
    .load_i       (accept),
    .load_instr_i (imem_rdata),
    .load_pc4_i   (pc_plus4),
    .consume_i    (consume),
    .flush_i      (redirect),
    .slot_o       (slot),
    .busy_o       (slot_busy)
`ifdef FETCH_PERF_EN
    ,
    .full_o       (hold_full),
    .slot_load_o  (slot_load)
`endif
  );

  // State, PC and drain-address registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state logic; redirect overrides stall and ack.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      if ((state_q != HOLD) && !imem_ack) state_d = DRAIN;
      else                                state_d = REQ;
    end else begin
      case (state_q)
        REQ, WAIT: begin
          if (imem_ack) state_d = slot_free ? REQ : HOLD;
          else          state_d = WAIT;
        end
        HOLD:    if (consume)  state_d = REQ;
        DRAIN:   if (imem_ack) state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  // Next PC and the frozen address of a request being drained.
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if (redirect) begin
      pc_d = redirect_pc & PC_ALIGN_MASK;
      if (req_state && !imem_ack) drain_addr_d = pc_q;
    end else if (accept) begin
      pc_d = pc_plus4;
    end
  end

  // Memory-side and slot outputs.
  always_comb begin
    imem_req    = !Rst && (state_q != HOLD);
    imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    instr_out   = slot.instr;
    pc_out      = slot.pc4;
    valid_out   = slot.valid;
    dbg_state_o = state_q;
  end

`ifdef FETCH_PERF_EN
  // Free-running, wrapping performance counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_fetched   <= 32'h0;
      perf_stall_cyc <= 32'h0;
      perf_flushed   <= 32'h0;
    end else begin
      if (slot_load)                           perf_fetched   <= perf_fetched + 32'd1;
      if (slot_busy && stall)                  perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (redirect && (slot_busy || hold_full)) perf_flushed   <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: memory model with random latency, random
// stall/redirect stimulus, expected-instruction queue checked by a monitor.
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cyc, perf_flushed;
`endif

  instr_fetch_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out),
    .dbg_state_o (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flushed   (perf_flushed)
`endif
  );

  // Clock
  always #5 Clk = ~Clk;

  // Scoreboard state: each entry is {instr, pc4} of an accepted fetch.
  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  int          n_pop = 0;
  // Reference model state
  logic [31:0] exp_pc = 32'h0;
  bit          stale = 1'b0;
  int          wait_cnt = 0;
  int          cur_lat = 0;
  bit          lat_set = 1'b0;
  int          min_lat = 0;
  int          max_lat = 0;
  int          m_pushed = 0;
  int          m_hold_flushed = 0;
  int          m_stall = 0;
  int          m_flushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the slot against the head of the expected queue.
  initial begin
    forever begin
      @(negedge Clk);
      #1;
      if (mon_en) begin
        if (valid_out) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slot_valid: got valid_out=1 expected empty slot (pc_out=%h)", pc_out);
          end else begin
            check("instr_out", instr_out, exp_q[0][63:32]);
            check("pc_out", pc_out, exp_q[0][31:0]);
            if (!stall && !redirect) begin
              void'(exp_q.pop_front());
              n_pop++;
            end
          end
        end else begin
          check("slot_empty", 32'(exp_q.size()), 32'd0);
          check("nop_instr", instr_out, 32'h0);
        end
      end
    end
  end

  // One cycle of stimulus: starts and ends at a negedge.
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    bit          ack;
    bit          req_s;
    logic [31:0] addr_s;
    int          sz;
    sz     = exp_q.size();
    req_s  = imem_req;
    addr_s = imem_addr;
    check("req_vs_occupancy", {31'b0, req_s}, (sz < 2) ? 32'd1 : 32'd0);
    ack = 1'b0;
    if (req_s) begin
      if (!lat_set) begin
        cur_lat = $urandom_range(min_lat, max_lat);
        lat_set = 1'b1;
      end
      ack = (wait_cnt >= cur_lat);
    end
    if (sz > 0 && st) m_stall++;
    if (rd && sz > 0) m_flushed++;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    imem_ack    = ack;
    imem_rdata  = ack ? (addr_s ^ KEY) : $urandom;
    @(posedge Clk);
    if (req_s) begin
      if (ack) begin
        wait_cnt = 0;
        lat_set  = 1'b0;
      end else begin
        wait_cnt++;
      end
    end
    if (rd) begin
      if (sz == 2) m_hold_flushed++;
      exp_q.delete();
      stale  = req_s && !ack;
      exp_pc = {tgt[31:2], 2'b00};
    end else if (ack) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        check("fetch_addr", addr_s, exp_pc);
        exp_q.push_back({exp_pc ^ KEY, exp_pc + 32'd4});
        m_pushed++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    int guard;
    // Reset
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    Rst = 1'b0;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    #1;
    mon_en = 1'b1;

    // Zero-wait memory, no stalls: one instruction per cycle.
    min_lat = 0;
    max_lat = 0;
    n_pop   = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0);
    check("throughput_pops", 32'(n_pop), 32'd19);

    // Stall three cycles: hold fills, request drops, then both drain in order.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Three-cycle latency; redirect while the request is waiting -> drain.
    min_lat = 3;
    max_lat = 3;
    guard = 0;
    while (!(imem_req && lat_set && wait_cnt == 1) && guard < 12) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    check("drain_setup", {31'b0, (imem_req && lat_set && wait_cnt == 1)}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100);
    check("drain_stale_pending", {31'b0, stale}, 32'd1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);

    // Redirect with stall while hold is occupied; misaligned target.
    min_lat = 0;
    max_lat = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    check("hold_occupied", 32'(exp_q.size()), 32'd2);
    step(1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Wrap-around at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    min_lat = 0;
    max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      step(st, rd, tgt);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched,
          32'(m_pushed - m_hold_flushed - ((exp_q.size() == 2) ? 1 : 0)));
    check("perf_stall_cyc", perf_stall_cyc, 32'(m_stall));
    check("perf_flushed", perf_flushed, 32'(m_flushed));
`endif

    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
